// File: rtl/uart_host_pkg.sv
// Shared types and byte constants for the UART host bridge.
// Holds the FSM state encoding, shift-register modes and frame/reply bytes.
package uart_host_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CMD,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_e;

   typedef enum logic [1:0] {
      SH_HOLD,
      SH_SHIFT_IN,
      SH_LOAD,
      SH_SHIFT_OUT
   } sh_mode_e;

   localparam logic [7:0] CMD_WR  = 8'h57;
   localparam logic [7:0] CMD_RD  = 8'h52;
   localparam logic [7:0] RSP_OK  = 8'h4B;
   localparam logic [7:0] RSP_ERR = 8'h45;
   localparam logic [7:0] RSP_TO  = 8'h54;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_host_shreg.sv
// Byte-wide shift register: assembles a little-endian field byte by byte,
// takes a parallel load, and serialises its contents LSB byte first.
module uart_host_shreg
   import uart_host_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  sh_mode_e     i_mode,
   input  logic [7:0]   i_byte,
   input  logic [W-1:0] i_load,
   output logic [W-1:0] o_q
);

   logic [W-1:0] r_q;
   logic [W-1:0] w_shift_in;
   logic [W-1:0] w_shift_out;

   // New bytes enter at the top so the first byte received ends up in the LSB.
   if (W == 8) begin : g_single
      assign w_shift_in  = i_byte;
      assign w_shift_out = '0;
   end else begin : g_multi
      assign w_shift_in  = {i_byte, r_q[W-1:8]};
      assign w_shift_out = {8'h00, r_q[W-1:8]};
   end

   // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q <= '0;
      end else begin
         case (i_mode)
            SH_SHIFT_IN:  r_q <= w_shift_in;
            SH_LOAD:      r_q <= i_load;
            SH_SHIFT_OUT: r_q <= w_shift_out;
            default:      r_q <= r_q;
         endcase
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/uart_host_bridge.sv
// UART-to-bus host bridge: decodes W/R command frames from the RX FIFO into single
// bus transactions and replies via the TX FIFO. Optional bus timeout: UART_HOST_TIMEOUT_EN.
module uart_host_bridge
   import uart_host_pkg::*;
#(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32,
   parameter int BUS_TO = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx_empty,
   input  logic [7:0]        r_data,
   output logic              rd_uart,
   input  logic              tx_full,
   output logic              wr_uart,
   output logic [7:0]        w_data,
   output logic              bus_req,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam int ADDR_BYTES = ADDR_W / 8;
   localparam int DATA_BYTES = DATA_W / 8;
   localparam int CNT_W      = $clog2(max_int(ADDR_BYTES, DATA_BYTES) + 1);
   localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
   localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);

   state_e            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic              r_we;
   logic              r_bus_req;
   logic              r_rsp_data;
   logic [7:0]        r_rsp_byte;

   logic              w_pop;
   logic              w_push;
   logic              w_ack;
   logic              w_timeout;
   sh_mode_e          w_addr_mode;
   sh_mode_e          w_data_mode;
   logic [ADDR_W-1:0] w_addr_q;
   logic [DATA_W-1:0] w_data_q;

   // FIFO handshakes are combinational so a byte is popped in the cycle it is consumed.
   assign w_pop  = ((r_state == ST_CMD) || (r_state == ST_ADDR) || (r_state == ST_DATA)) && !rx_empty;
   assign w_push = (r_state == ST_RESP) && !tx_full;
   assign w_ack  = (r_state == ST_BUS) && r_bus_req && bus_ack;

`ifdef UART_HOST_TIMEOUT_EN
   localparam int TO_W = $clog2(BUS_TO + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(BUS_TO - 1);

   logic [TO_W-1:0] r_to_cnt;

   always_ff @(posedge clk) begin
      if (reset || !r_bus_req) begin
         r_to_cnt <= '0;
      end else begin
         r_to_cnt <= r_to_cnt + 1'b1;
      end
   end

   assign w_timeout = (r_state == ST_BUS) && r_bus_req && !bus_ack && (r_to_cnt == TO_LAST);
`else
   logic [31:0] w_unused_bus_to;

   assign w_unused_bus_to = 32'(BUS_TO);
   assign w_timeout       = 1'b0;
`endif

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_addr_mode = SH_HOLD;
      w_data_mode = SH_HOLD;
      if ((r_state == ST_ADDR) && w_pop) begin
         w_addr_mode = SH_SHIFT_IN;
      end
      if ((r_state == ST_DATA) && w_pop) begin
         w_data_mode = SH_SHIFT_IN;
      end else if (w_ack && !r_we) begin
         w_data_mode = SH_LOAD;
      end else if (w_push && r_rsp_data) begin
         w_data_mode = SH_SHIFT_OUT;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_we       <= 1'b0;
         r_bus_req  <= 1'b0;
         r_rsp_data <= 1'b0;
         r_rsp_byte <= 8'h00;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_state <= ST_CMD;
               r_cnt   <= '0;
            end
            ST_CMD: if (w_pop) begin
               r_cnt <= '0;
               if ((r_data == CMD_WR) || (r_data == CMD_RD)) begin
                  r_we    <= (r_data == CMD_WR);
                  r_state <= ST_ADDR;
               end else begin
                  r_rsp_byte <= RSP_ERR;
                  r_rsp_data <= 1'b0;
                  r_state    <= ST_RESP;
               end
            end
            ST_ADDR: if (w_pop) begin
               if (r_cnt == ADDR_LAST) begin
                  r_cnt   <= '0;
                  r_state <= r_we ? ST_DATA : ST_BUS;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_DATA: if (w_pop) begin
               if (r_cnt == DATA_LAST) begin
                  r_cnt   <= '0;
                  r_state <= ST_BUS;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_BUS: begin
               if (!r_bus_req) begin
                  r_bus_req <= 1'b1;
               end else if (w_ack) begin
                  r_bus_req  <= 1'b0;
                  r_cnt      <= '0;
                  r_rsp_data <= !r_we;
                  r_rsp_byte <= RSP_OK;
                  r_state    <= ST_RESP;
               end else if (w_timeout) begin
                  r_bus_req  <= 1'b0;
                  r_cnt      <= '0;
                  r_rsp_data <= 1'b0;
                  r_rsp_byte <= RSP_TO;
                  r_state    <= ST_RESP;
               end
            end
            ST_RESP: if (w_push) begin
               if (r_rsp_data && (r_cnt != DATA_LAST)) begin
                  r_cnt <= r_cnt + 1'b1;
               end else begin
                  r_cnt      <= '0;
                  r_rsp_data <= 1'b0;
                  r_state    <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   uart_host_shreg #(.W(ADDR_W)) u_addr_shreg (
      .clk    (clk),
      .reset  (reset),
      .i_mode (w_addr_mode),
      .i_byte (r_data),
      .i_load ('0),
      .o_q    (w_addr_q)
   );

   uart_host_shreg #(.W(DATA_W)) u_data_shreg (
      .clk    (clk),
      .reset  (reset),
      .i_mode (w_data_mode),
      .i_byte (r_data),
      .i_load (bus_rdata),
      .o_q    (w_data_q)
   );

   assign rd_uart   = w_pop;
   assign wr_uart   = w_push;
   assign w_data    = r_rsp_data ? w_data_q[7:0] : r_rsp_byte;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_we;
   assign bus_addr  = w_addr_q;
   assign bus_wdata = w_data_q;

endmodule

// File: tb/tb_uart_host_bridge.sv
// Self-checking bench for uart_host_bridge: table-driven frames plus hand-written
// sequences for back-pressure, mid-frame reset and a missing bus acknowledge.
module tb_uart_host_bridge;

   typedef struct {
      logic [47:0] bytes;     // frame, first byte in [7:0]
      int          n;
      logic [31:0] rdata;
      int          ack_dly;
      logic [7:0]  exp_addr;
      logic        exp_we;
      logic [31:0] exp_wdata;
   } vec_t;

   logic        clk       = 1'b0;
   logic        reset     = 1'b1;
   logic        rx_empty  = 1'b1;
   logic [7:0]  r_data    = 8'h00;
   logic        tx_full   = 1'b0;
   logic        bus_ack   = 1'b0;
   logic [31:0] bus_rdata = 32'h0;
   logic        rd_uart;
   logic        wr_uart;
   logic [7:0]  w_data;
   logic        bus_req;
   logic        bus_we;
   logic [7:0]  bus_addr;
   logic [31:0] bus_wdata;

   logic [7:0] rx_q[$];
   logic [7:0] tx_got[$];
   logic [7:0] exp_q[$];
   int cyc      = 0;
   int last_pop = 0;
   int pop_cnt  = 0;
   int rd_viol  = 0;
   int wr_viol  = 0;
   int n_checks = 0;
   int n_fail   = 0;

   uart_host_bridge #(.ADDR_W(8), .DATA_W(32), .BUS_TO(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .rx_empty  (rx_empty),
      .r_data    (r_data),
      .rd_uart   (rd_uart),
      .tx_full   (tx_full),
      .wr_uart   (wr_uart),
      .w_data    (w_data),
      .bus_req   (bus_req),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ack   (bus_ack),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   // UART FIFO models: RX pops on rd_uart, TX captures on wr_uart.
   always @(posedge clk) begin
      if (rd_uart) begin
         if (rx_q.size() == 0) rd_viol++;
         else rx_q.delete(0);
         pop_cnt++;
         last_pop = cyc;
      end
      if (wr_uart) begin
         if (tx_full) wr_viol++;
         tx_got.push_back(w_data);
      end
      cyc++;
      rx_empty <= (rx_q.size() == 0);
      r_data   <= (rx_q.size() != 0) ? rx_q[0] : 8'h00;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_bus_req(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         if (bus_req) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      check("bus_req rise", {31'b0, bus_req}, 32'h1);
   endtask

   task automatic drain(input string tag);
      int         want;
      logic [7:0] e;
      logic [7:0] g;
      want = exp_q.size();
      for (int i = 0; i < 300 && tx_got.size() < want; i++) @(negedge clk);
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = 8'hxx;
         if (tx_got.size() > 0) g = tx_got.pop_front();
         check({tag, " tx byte"}, {24'b0, g}, {24'b0, e});
      end
      repeat (4) @(negedge clk);
      check({tag, " tx extra"}, tx_got.size(), 32'h0);
   endtask

   task automatic push_read_reply(input logic [31:0] d);
      for (int k = 0; k < 4; k++) exp_q.push_back(d[8*k +: 8]);
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      logic [47:0] b;
      logic [7:0]  cmd;
      int          pops0;
      bit          ok;
      b     = v.bytes;
      cmd   = b[7:0];
      pops0 = pop_cnt;
      for (int i = 0; i < v.n; i++) rx_q.push_back(b[8*i +: 8]);
      if (cmd == 8'h57)      exp_q.push_back(8'h4B);
      else if (cmd == 8'h52) push_read_reply(v.rdata);
      else                   exp_q.push_back(8'h45);
      if (cmd == 8'h57 || cmd == 8'h52) begin
         wait_bus_req(ok);
         if (ok) begin
            check({tag, " req latency"}, cyc - last_pop, 32'd2);
            check({tag, " addr"}, {24'b0, bus_addr}, {24'b0, v.exp_addr});
            check({tag, " we"}, {31'b0, bus_we}, {31'b0, v.exp_we});
            if (v.exp_we) check({tag, " wdata"}, bus_wdata, v.exp_wdata);
            repeat (v.ack_dly) @(negedge clk);
            if (v.ack_dly > 0)
               check({tag, " hold"}, {22'b0, bus_req, bus_we, bus_addr}, {22'b0, 1'b1, v.exp_we, v.exp_addr});
            bus_ack   = 1'b1;
            bus_rdata = v.rdata;
            @(negedge clk);
            bus_ack   = 1'b0;
            bus_rdata = $urandom();
            check({tag, " req drop"}, {31'b0, bus_req}, 32'h0);
            check({tag, " first reply"}, {23'b0, wr_uart, w_data}, {23'b0, 1'b1, exp_q[0]});
         end
      end
      drain(tag);
      check({tag, " pops"}, pop_cnt - pops0, v.n);
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs[6];
      vec_t v;
      bit   ok;
      int   hi;
      int   pops0;

      vecs[0] = '{48'hDEADBEEF1057, 6, 32'h55AA55AA, 3, 8'h10, 1'b1, 32'hDEADBEEF};
      vecs[1] = '{48'h000000002052, 2, 32'h12345678, 1, 8'h20, 1'b0, 32'h0};
      vecs[2] = '{48'h00000000005A, 1, 32'h0,        0, 8'h00, 1'b0, 32'h0};
      vecs[3] = '{48'h000000000052, 2, 32'hA5C30F1E, 0, 8'h00, 1'b0, 32'h0};
      vecs[4] = '{48'h04030201FF57, 6, 32'h0,        0, 8'hFF, 1'b1, 32'h04030201};
      vecs[5] = '{48'h00000000004B, 1, 32'h0,        0, 8'h00, 1'b0, 32'h0};

      repeat (3) @(negedge clk);
      check("reset ctrl", {28'b0, bus_req, bus_we, rd_uart, wr_uart}, 32'h0);
      check("reset w_data", {24'b0, w_data}, 32'h0);
      check("reset addr", {24'b0, bus_addr}, 32'h0);
      check("reset wdata", bus_wdata, 32'h0);
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("v%0d", i));

      // Read reply under TX back-pressure.
      rx_q.push_back(8'h52);
      rx_q.push_back(8'h30);
      push_read_reply(32'hCAFEF00D);
      wait_bus_req(ok);
      tx_full   = 1'b1;
      bus_ack   = 1'b1;
      bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      repeat (9) @(negedge clk);
      check("txfull held", tx_got.size(), 32'h0);
      tx_full = 1'b0;
      drain("txfull");

      // Reset in the middle of a write frame.
      rx_q.push_back(8'h57);
      rx_q.push_back(8'h10);
      rx_q.push_back(8'hAA);
      for (int i = 0; i < 50 && rx_q.size() > 0; i++) @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      check("midreset ctrl", {28'b0, bus_req, bus_we, rd_uart, wr_uart}, 32'h0);
      check("midreset addr", {24'b0, bus_addr}, 32'h0);
      check("midreset wdata", bus_wdata, 32'h0);
      reset = 1'b0;
      v = '{48'h112233441157, 6, 32'h0, 2, 8'h11, 1'b1, 32'h11223344};
      run_vec(v, "after reset");

      // Missing acknowledge; a queued error byte must wait in the RX FIFO.
      rx_q.push_back(8'h52);
      rx_q.push_back(8'h40);
      wait_bus_req(ok);
      rx_q.push_back(8'h5A);
      pops0 = pop_cnt;
`ifdef UART_HOST_TIMEOUT_EN
      hi = 1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_req) hi++;
      end
      check("timeout window", hi, 32'd8);
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h45);
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      check("late ack ignored", {31'b0, bus_req}, 32'h0);
      drain("timeout");
`else
      hi = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus_req) hi++;
      end
      check("no-ack req held", hi, 32'd20);
      check("rx held in BUS", pop_cnt - pops0, 32'h0);
      push_read_reply(32'h0BADF00D);
      exp_q.push_back(8'h45);
      bus_ack   = 1'b1;
      bus_rdata = 32'h0BADF00D;
      @(negedge clk);
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
      drain("slow ack");
`endif

      // Acknowledge with no request outstanding.
      bus_ack = 1'b1;
      @(negedge clk);
      bus_ack = 1'b0;
      repeat (5) @(negedge clk);
      check("stray ack req", {31'b0, bus_req}, 32'h0);
      check("stray ack tx", tx_got.size(), 32'h0);

      check("rd while empty", rd_viol, 32'h0);
      check("wr while full", wr_viol, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
